// File: rtl/apb_pkg.sv
// Shared APB4 request/response types and the bridge state encoding.
package apb_pkg;

  typedef struct packed {
    logic        psel;
    logic        penable;
    logic        pwrite;
    logic [2:0]  pprot;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [3:0]  pstrb;
  } apb_req_t;

  typedef struct packed {
    logic        pready;
    logic        pslverr;
    logic [31:0] prdata;
  } apb_resp_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } bridge_state_e;

endpackage

// File: rtl/apb_master_bridge.sv
// Command-stream to APB4 master bridge: one transfer in flight, bounded
// access-phase wait, one response per command.
module apb_master_bridge
  import apb_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 256,
  parameter int unsigned TCNT_W         = 16
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  // Both channels: a beat transfers on a rising edge where valid & ready are
  // high; a source keeps valid and its payload stable until that edge.
  input  logic          cmd_valid_i,
  output logic          cmd_ready_o,
  input  logic [31:0]   cmd_addr_i,
  input  logic          cmd_write_i,
  input  logic [31:0]   cmd_wdata_i,
  input  logic [3:0]    cmd_strb_i,
  input  logic [2:0]    cmd_prot_i,
  output logic          rsp_valid_o,
  input  logic          rsp_ready_i,
  output logic [31:0]   rsp_rdata_o,
  output logic          rsp_err_o,
  output logic          rsp_timeout_o,
  output apb_req_t      apb_req_o,
  input  apb_resp_t     apb_resp_i,
  output bridge_state_e dbg_state_o
);

  localparam bit TIMEOUT_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [TCNT_W-1:0] TCNT_LAST =
    TCNT_W'((TIMEOUT_CYCLES != 0) ? TIMEOUT_CYCLES - 1 : 0);

  bridge_state_e     state_q, state_d;
  apb_req_t          req_q, req_d;
  logic              cmd_ready_q, cmd_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [31:0]       rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic [TCNT_W-1:0] tcnt_q, tcnt_d;

  always_comb begin
    state_d       = state_q;
    req_d         = req_q;
    cmd_ready_d   = 1'b0;
    rsp_valid_d   = rsp_valid_q;
    rsp_rdata_d   = rsp_rdata_q;
    rsp_err_d     = rsp_err_q;
    rsp_timeout_d = rsp_timeout_q;
    tcnt_d        = tcnt_q;

    case (state_q)
      ST_IDLE: begin
        req_d       = '0;
        cmd_ready_d = 1'b1;
        if (cmd_valid_i && cmd_ready_q) begin
          // The request register doubles as the command latch; read
          // transfers drive no write data or strobes onto the bus.
          cmd_ready_d   = 1'b0;
          state_d       = ST_SETUP;
          req_d.psel    = 1'b1;
          req_d.penable = 1'b0;
          req_d.pwrite  = cmd_write_i;
          req_d.pprot   = cmd_prot_i;
          req_d.paddr   = cmd_addr_i;
          req_d.pwdata  = cmd_write_i ? cmd_wdata_i : 32'h0;
          req_d.pstrb   = cmd_write_i ? cmd_strb_i : 4'h0;
        end
      end

      ST_SETUP: begin
        state_d       = ST_ACCESS;
        req_d.penable = 1'b1;
        tcnt_d        = '0;
      end

      ST_ACCESS: begin
        if (apb_resp_i.pready) begin
          state_d       = ST_RESP;
          req_d         = '0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = req_q.pwrite ? 32'h0 : apb_resp_i.prdata;
          rsp_err_d     = apb_resp_i.pslverr;
          rsp_timeout_d = 1'b0;
        end else if (TIMEOUT_EN && (tcnt_q == TCNT_LAST)) begin
          state_d       = ST_RESP;
          req_d         = '0;
          rsp_valid_d   = 1'b1;
          rsp_rdata_d   = 32'h0;
          rsp_err_d     = 1'b1;
          rsp_timeout_d = 1'b1;
        end else begin
          tcnt_d = tcnt_q + TCNT_W'(1);
        end
      end

      ST_RESP: begin
        req_d = '0;
        if (rsp_ready_i) begin
          state_d     = ST_IDLE;
          rsp_valid_d = 1'b0;
          cmd_ready_d = 1'b1;
        end
      end

      default: begin
        state_d     = ST_IDLE;
        req_d       = '0;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= ST_IDLE;
      req_q         <= '0;
      cmd_ready_q   <= 1'b0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= 32'h0;
      rsp_err_q     <= 1'b0;
      rsp_timeout_q <= 1'b0;
      tcnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      req_q         <= req_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_err_q     <= rsp_err_d;
      rsp_timeout_q <= rsp_timeout_d;
      tcnt_q        <= tcnt_d;
    end
  end

  assign cmd_ready_o   = cmd_ready_q;
  assign rsp_valid_o   = rsp_valid_q;
  assign rsp_rdata_o   = rsp_rdata_q;
  assign rsp_err_o     = rsp_err_q;
  assign rsp_timeout_o = rsp_timeout_q;
  assign apb_req_o     = req_q;
  assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Self-checking bench for apb_master_bridge: directed scenarios plus a short
// randomized run, responses checked against an expected queue.
module tb_apb_master_bridge;
  import apb_pkg::*;

  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic [31:0]   cmd_addr = '0;
  logic          cmd_write = 1'b0;
  logic [31:0]   cmd_wdata = '0;
  logic [3:0]    cmd_strb = '0;
  logic [2:0]    cmd_prot = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [31:0]   rsp_rdata;
  logic          rsp_err;
  logic          rsp_timeout;
  apb_req_t      apb_req;
  apb_resp_t     apb_resp = '0;
  bridge_state_e dbg_state;

  // Expected response word: {timeout, err, rdata}
  logic [33:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  apb_master_bridge #(.TIMEOUT_CYCLES(TO), .TCNT_W(16)) dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .cmd_addr_i   (cmd_addr),
    .cmd_write_i  (cmd_write),
    .cmd_wdata_i  (cmd_wdata),
    .cmd_strb_i   (cmd_strb),
    .cmd_prot_i   (cmd_prot),
    .rsp_valid_o  (rsp_valid),
    .rsp_ready_i  (rsp_ready),
    .rsp_rdata_o  (rsp_rdata),
    .rsp_err_o    (rsp_err),
    .rsp_timeout_o(rsp_timeout),
    .apb_req_o    (apb_req),
    .apb_resp_i   (apb_resp),
    .dbg_state_o  (dbg_state)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // ---------------- driver tasks and model ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_cmd(input logic [31:0] a, input logic w, input logic [31:0] d,
                           input logic [3:0] s, input logic [2:0] p);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_write = w;
    cmd_wdata = d;
    cmd_strb  = s;
    cmd_prot  = p;
  endtask

  task automatic set_slave(input logic rdy, input logic err, input logic [31:0] rd);
    apb_resp.pready  = rdy;
    apb_resp.pslverr = err;
    apb_resp.prdata  = rd;
  endtask

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (cmd_ready === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  task automatic wait_rsp(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (rsp_valid === 1'b1) begin
        ok = 1'b1;
        return;
      end
      tick();
    end
  endtask

  // Expected bus image: reads carry no write data or strobes.
  function automatic apb_req_t make_req(input logic [31:0] a, input logic w,
                                        input logic [31:0] d, input logic [3:0] s,
                                        input logic [2:0] p, input logic en);
    apb_req_t r;
    r.psel    = 1'b1;
    r.penable = en;
    r.pwrite  = w;
    r.pprot   = p;
    r.paddr   = a;
    r.pwdata  = w ? d : 32'h0;
    r.pstrb   = w ? s : 4'h0;
    return r;
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    #3;
    n_tests++;
    if (apb_req !== '0) begin
      n_fail++; $display("FAIL reset_req: got %h exp 0", apb_req);
    end
    n_tests++;
    if ({cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata} !== 36'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: got ready=%b valid=%b err=%b to=%b rdata=%h exp all 0",
               cmd_ready, rsp_valid, rsp_err, rsp_timeout, rsp_rdata);
    end
    n_tests++;
    if (dbg_state !== ST_IDLE) begin
      n_fail++; $display("FAIL reset_state: got %0d exp %0d", dbg_state, ST_IDLE);
    end
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    n_tests++;
    if (cmd_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_release_ready: got %b exp 1", cmd_ready);
    end
  endtask

  task automatic test_write_zero_wait(input logic [31:0] addr, input logic [31:0] wdata);
    bit ok;
    apb_req_t er;
    logic [33:0] exp;
    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL wr_wait_ready: got 0 exp 1"); end
    rsp_ready = 1'b1;
    set_slave(1'b0, 1'b0, 32'h0);
    drive_cmd(addr, 1'b1, wdata, 4'hF, 3'b010);
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    er = make_req(addr, 1'b1, wdata, 4'hF, 3'b010, 1'b0);
    tick();                                   // cycle 1: SETUP
    cmd_valid = 1'b0;
    cmd_addr  = ~addr;
    cmd_wdata = ~wdata;
    n_tests++;
    if (apb_req !== er || dbg_state !== ST_SETUP || cmd_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL wr_setup: got req=%h st=%0d rdy=%b exp req=%h st=%0d rdy=0",
               apb_req, dbg_state, cmd_ready, er, ST_SETUP);
    end
    tick();                                   // cycle 2: ACCESS
    er.penable = 1'b1;
    n_tests++;
    if (apb_req !== er) begin
      n_fail++; $display("FAIL wr_access: got %h exp %h", apb_req, er);
    end
    set_slave(1'b1, 1'b0, 32'hA5A5_A5A5);
    tick();                                   // cycle 3: response
    set_slave(1'b0, 1'b0, 32'h0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    n_tests++;
    if (rsp_valid !== 1'b1 || apb_req.psel !== 1'b0 ||
        {rsp_timeout, rsp_err, rsp_rdata} !== exp) begin
      n_fail++;
      $display("FAIL wr_rsp: got valid=%b psel=%b rsp=%h exp valid=1 psel=0 rsp=%h",
               rsp_valid, apb_req.psel, {rsp_timeout, rsp_err, rsp_rdata}, exp);
    end
    tick();                                   // cycle 4
    n_tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL wr_after: got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, cmd_ready);
    end
  endtask

  task automatic test_read_wait3();
    bit ok;
    apb_req_t er;
    logic [33:0] exp;
    logic [31:0] addr = 32'h1000_0008;
    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rd_wait_ready: got 0 exp 1"); end
    drive_cmd(addr, 1'b0, 32'h5555_5555, 4'hF, 3'b001);
    exp_q.push_back({1'b0, 1'b0, 32'h1234_5678});
    er = make_req(addr, 1'b0, 32'h5555_5555, 4'hF, 3'b001, 1'b0);
    tick();                                   // cycle 1: SETUP
    cmd_valid = 1'b0;
    cmd_addr  = 32'hFFFF_0000;
    cmd_write = 1'b1;
    n_tests++;
    if (apb_req !== er) begin
      n_fail++; $display("FAIL rd_setup: got %h exp %h", apb_req, er);
    end
    er.penable = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();                                 // cycles 2..5: ACCESS
      n_tests++;
      if (apb_req !== er || rsp_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL rd_access_%0d: got req=%h valid=%b exp req=%h valid=0",
                 k, apb_req, rsp_valid, er);
      end
      if (k == 3) set_slave(1'b1, 1'b0, 32'h1234_5678);
      else        set_slave(1'b0, 1'b1, 32'hDEAD_0000 + 32'(k));
    end
    tick();                                   // cycle 6: response
    set_slave(1'b0, 1'b0, 32'h0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    n_tests++;
    if (rsp_valid !== 1'b1 || {rsp_timeout, rsp_err, rsp_rdata} !== exp) begin
      n_fail++;
      $display("FAIL rd_rsp: got valid=%b rsp=%h exp valid=1 rsp=%h",
               rsp_valid, {rsp_timeout, rsp_err, rsp_rdata}, exp);
    end
    tick();
  endtask

  task automatic test_slave_error();
    bit ok;
    logic [33:0] exp;
    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL err_wait_ready: got 0 exp 1"); end
    drive_cmd(32'h1000_0010, 1'b0, 32'h0, 4'h0, 3'b000);
    exp_q.push_back({1'b0, 1'b1, 32'hFFFF_FFFF});
    tick();
    cmd_valid = 1'b0;
    tick();
    set_slave(1'b1, 1'b1, 32'hFFFF_FFFF);
    tick();
    set_slave(1'b0, 1'b0, 32'h0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    n_tests++;
    if (rsp_valid !== 1'b1 || {rsp_timeout, rsp_err, rsp_rdata} !== exp) begin
      n_fail++;
      $display("FAIL err_rsp: got valid=%b rsp=%h exp valid=1 rsp=%h",
               rsp_valid, {rsp_timeout, rsp_err, rsp_rdata}, exp);
    end
    tick();
  endtask

  task automatic test_timeout(input bit ready_on_last);
    bit ok;
    int cnt;
    logic [33:0] exp;
    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL to_wait_ready: got 0 exp 1"); end
    drive_cmd(32'h1000_0030, 1'b0, 32'h0, 4'h0, 3'b000);
    if (ready_on_last) exp_q.push_back({1'b0, 1'b0, 32'hCAFE_F00D});
    else               exp_q.push_back({1'b1, 1'b1, 32'h0});
    set_slave(1'b0, 1'b0, 32'h7777_7777);
    tick();
    cmd_valid = 1'b0;
    cnt = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (!(apb_req.psel === 1'b1 && apb_req.penable === 1'b1)) break;
      cnt++;
      if (ready_on_last && cnt == int'(TO)) set_slave(1'b1, 1'b0, 32'hCAFE_F00D);
    end
    set_slave(1'b0, 1'b0, 32'h0);
    n_tests++;
    if (cnt != int'(TO)) begin
      n_fail++; $display("FAIL to_access_cycles(%0d): got %0d exp %0d", ready_on_last, cnt, TO);
    end
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    n_tests++;
    if (rsp_valid !== 1'b1 || apb_req.psel !== 1'b0 ||
        {rsp_timeout, rsp_err, rsp_rdata} !== exp) begin
      n_fail++;
      $display("FAIL to_rsp(%0d): got valid=%b psel=%b rsp=%h exp valid=1 psel=0 rsp=%h",
               ready_on_last, rsp_valid, apb_req.psel, {rsp_timeout, rsp_err, rsp_rdata}, exp);
    end
    tick();
  endtask

  task automatic test_backpressure();
    bit ok;
    apb_req_t er;
    logic [33:0] exp;
    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL bp_wait_ready: got 0 exp 1"); end
    rsp_ready = 1'b0;
    drive_cmd(32'h1000_0080, 1'b1, 32'h1111_2222, 4'h3, 3'b000);
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    tick();
    cmd_valid = 1'b0;
    tick();
    set_slave(1'b1, 1'b0, 32'h0);
    tick();                                   // cycle 3: response held
    set_slave(1'b0, 1'b0, 32'h0);
    drive_cmd(32'h1000_0084, 1'b0, 32'h0, 4'h0, 3'b100);
    exp_q.push_back({1'b0, 1'b0, 32'h0BAD_CAFE});
    for (int i = 0; i < 5; i++) begin
      n_tests++;
      if (rsp_valid !== 1'b1 || {rsp_timeout, rsp_err, rsp_rdata} !== exp_q[0] ||
          cmd_ready !== 1'b0 || apb_req.psel !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold_%0d: got valid=%b rsp=%h rdy=%b psel=%b exp valid=1 rsp=%h rdy=0 psel=0",
                 i, rsp_valid, {rsp_timeout, rsp_err, rsp_rdata}, cmd_ready, apb_req.psel, exp_q[0]);
      end
      tick();
    end
    rsp_ready = 1'b1;
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    n_tests++;
    if (rsp_valid !== 1'b1 || {rsp_timeout, rsp_err, rsp_rdata} !== exp) begin
      n_fail++;
      $display("FAIL bp_rsp: got valid=%b rsp=%h exp valid=1 rsp=%h",
               rsp_valid, {rsp_timeout, rsp_err, rsp_rdata}, exp);
    end
    tick();
    n_tests++;
    if (rsp_valid !== 1'b0 || cmd_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: got valid=%b ready=%b exp valid=0 ready=1", rsp_valid, cmd_ready);
    end
    tick();                                   // queued command in SETUP
    cmd_valid = 1'b0;
    er = make_req(32'h1000_0084, 1'b0, 32'h0, 4'h0, 3'b100, 1'b0);
    n_tests++;
    if (apb_req !== er) begin
      n_fail++; $display("FAIL bp_queued_setup: got %h exp %h", apb_req, er);
    end
    tick();
    set_slave(1'b1, 1'b0, 32'h0BAD_CAFE);
    tick();
    set_slave(1'b0, 1'b0, 32'h0);
    exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
    n_tests++;
    if (rsp_valid !== 1'b1 || {rsp_timeout, rsp_err, rsp_rdata} !== exp) begin
      n_fail++;
      $display("FAIL bp_queued_rsp: got valid=%b rsp=%h exp valid=1 rsp=%h",
               rsp_valid, {rsp_timeout, rsp_err, rsp_rdata}, exp);
    end
    tick();
  endtask

  task automatic test_reset_mid_access();
    bit ok;
    bit seen;
    wait_ready(ok);
    n_tests++;
    if (!ok) begin n_fail++; $display("FAIL rst_wait_ready: got 0 exp 1"); end
    drive_cmd(32'h1000_0020, 1'b0, 32'h0, 4'h0, 3'b000);
    exp_q.push_back({1'b0, 1'b0, 32'h0});
    set_slave(1'b0, 1'b0, 32'h0);
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();                                   // second ACCESS wait cycle
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    n_tests++;
    if (apb_req.psel !== 1'b0 || apb_req.penable !== 1'b0 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_async_drop: got psel=%b penable=%b valid=%b exp 0 0 0",
               apb_req.psel, apb_req.penable, rsp_valid);
    end
    tick();
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (rsp_valid !== 1'b0) seen = 1'b1;
    end
    n_tests++;
    if (seen) begin n_fail++; $display("FAIL rst_no_rsp: got rsp_valid=1 exp 0"); end
    test_write_zero_wait(32'h1000_0100, 32'h0102_0304);
  endtask

  task automatic test_random();
    bit ok;
    logic        w, err;
    logic [31:0] a, d, rd;
    int          waits;
    logic [33:0] exp;
    for (int t = 0; t < 8; t++) begin
      w     = 1'($urandom_range(0, 1));
      err   = 1'($urandom_range(0, 1));
      a     = {$urandom_range(0, 65535), 16'h0} | 32'($urandom_range(0, 255) * 4);
      d     = $urandom;
      rd    = $urandom;
      waits = $urandom_range(0, 3);
      wait_ready(ok);
      n_tests++;
      if (!ok) begin n_fail++; $display("FAIL rand_wait_ready_%0d: got 0 exp 1", t); end
      drive_cmd(a, w, d, 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)));
      exp_q.push_back({1'b0, err, w ? 32'h0 : rd});
      tick();
      cmd_valid = 1'b0;
      tick();
      for (int i = 0; i < waits; i++) begin
        set_slave(1'b0, 1'b1, $urandom);
        tick();
      end
      set_slave(1'b1, err, rd);
      tick();
      set_slave(1'b0, 1'b0, 32'h0);
      wait_rsp(ok);
      exp = (exp_q.size() > 0) ? exp_q.pop_front() : 34'h3_FFFF_FFFF;
      n_tests++;
      if (!ok || {rsp_timeout, rsp_err, rsp_rdata} !== exp) begin
        n_fail++;
        $display("FAIL rand_rsp_%0d: got valid=%b rsp=%h exp valid=1 rsp=%h",
                 t, rsp_valid, {rsp_timeout, rsp_err, rsp_rdata}, exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_write_zero_wait(32'h1000_0040, 32'hDEAD_BEEF);
    test_read_wait3();
    test_slave_error();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_backpressure();
    test_reset_mid_access();
    test_random();
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++; $display("FAIL scoreboard_drain: got %0d left exp 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_master_bridge.md
Name: apb_master_bridge

Overview:
- Converts a simple valid/ready command stream into APB4 transfers (setup phase, then access phase) on an `apb_pkg::apb_req_t` request and `apb_pkg::apb_resp_t` response pair.
- Returns one response per command on a valid/ready response channel.
- Sits between tile-internal initiators (debug/config sequencers) and the APB peripheral fabric.
- One transfer in flight at a time, with a bounded-wait timeout.

Parameters:
- TIMEOUT_CYCLES, 256, maximum access-phase cycles without pready before the bridge aborts. 0 disables the timeout.
- TCNT_W, 16, width of the timeout counter. Must satisfy TIMEOUT_CYCLES < 2**TCNT_W.

Ports:
- clk_i  in  1  clock; all logic on its rising edge
- rst_ni  in  1  asynchronous active-low reset
- cmd_valid_i  in  1  command valid
- cmd_ready_o  out  1  command accepted when valid & ready
- cmd_addr_i  in  32  target address
- cmd_write_i  in  1  1 = write, 0 = read
- cmd_wdata_i  in  32  write data
- cmd_strb_i  in  4  write byte strobes
- cmd_prot_i  in  3  pprot value
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  response consumed when valid & ready
- rsp_rdata_o  out  32  read data; 0 for writes and on timeout
- rsp_err_o  out  1  pslverr captured, or timeout
- rsp_timeout_o  out  1  transfer aborted by timeout
- apb_req_o  out  apb_req_t  APB request
- apb_resp_i  in  apb_resp_t  APB response

Behaviour:
- Reset values: all apb_req_o fields 0; cmd_ready_o=0; rsp_valid_o=0; rsp_rdata_o=0; rsp_err_o=0; rsp_timeout_o=0; FSM in IDLE; timeout counter 0.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - cmd_ready_o=1 (registered, derived from state).
  - On cmd_valid_i, latch addr/write/wdata/strb/prot and go to SETUP.
  - apb_req_o is all zeros.
- SETUP (exactly one cycle):
  - psel=1, penable=0.
  - paddr, pwrite, pprot from the latched command.
  - Writes: pwdata and pstrb = latched values.
  - Reads: pwdata=0, pstrb=0.
  - Next state ACCESS; timeout counter cleared.
- ACCESS:
  - psel=1, penable=1; all other fields identical to SETUP and held stable.
  - pready=1 sampled this cycle: capture rdata (prdata for reads, 0 for writes), err=pslverr, timeout=0; go to RESP.
  - pready=0: counter increments.
  - TIMEOUT_CYCLES>0 and counter == TIMEOUT_CYCLES-1 with pready=0: go to RESP with rdata=0, err=1, timeout=1.
- RESP:
  - apb_req_o is all zeros; cmd_ready_o=0.
  - rsp_valid_o=1; response fields held stable until rsp_ready_i.
  - On handshake go to IDLE; rsp_valid_o=0 next cycle.
- Latency: command accepted in cycle N → SETUP N+1 → ACCESS N+2 → earliest rsp_valid_o in N+3. Each pready=0 cycle adds one.
- Throughput: at most one command per 4 cycles. No new command is accepted while a response is pending.
- pslverr and prdata are ignored when pready=0.
- cmd_* changes after acceptance have no effect on the bus.
- Timeout exactly at the boundary: pready=1 in the same cycle the counter would expire means normal completion, not timeout.
- Reset mid-transfer: psel/penable fall asynchronously; the transfer is lost with no response. Reset deassertion returns to IDLE.
- rsp_ready_i held high is legal: the response is consumed in its first valid cycle.

Test Plan:
- Write, zero wait: cmd addr=0x1000_0040, wdata=0xDEAD_BEEF, strb=0xF accepted at cycle 0 → SETUP at 1 (psel=1, penable=0, pwrite=1), ACCESS at 2 with pready=1 → rsp_valid at 3, err=0, rdata=0, timeout=0.
- Read, 3 wait states: addr=0x1000_0008; pready low 3 ACCESS cycles then high with prdata=0x1234_5678 → paddr/psel stable for 4 ACCESS cycles, pstrb=0, pwdata=0; rsp rdata=0x1234_5678 at cycle 6.
- Slave error: read with pready=1, pslverr=1, prdata=0xFFFF_FFFF → rsp err=1, timeout=0, rdata=0xFFFF_FFFF.
- Timeout (TIMEOUT_CYCLES=8): pready held 0 → exactly 8 ACCESS cycles, psel falls, rsp err=1, timeout=1, rdata=0. Separately, pready=1 on the 8th ACCESS cycle → normal completion.
- Response backpressure: rsp_ready_i=0 for 5 cycles → rsp fields stable, cmd_ready_o=0, psel=0, new cmd_valid_i not accepted. After the handshake, cmd_ready_o=1 the next cycle and the queued command then starts.
- Reset mid-ACCESS: assert rst_ni=0 asynchronously during a wait state → psel/penable drop before the next edge, no rsp_valid_o. After release, a fresh write completes normally.
